// File: rtl/rx_dma_writer_if.sv
// PHY RX FIFO read port and PCIe master command FIFO write port of rx_dma_writer.
`timescale 1ns/1ps
interface rx_dma_writer_if;
    logic [17:0] phy_dout;
    logic        phy_empty;
    logic        phy_rd_en;
    logic [17:0] mst_din;
    logic        mst_full;
    logic        mst_wr_en;

    modport master (
        input  phy_dout, phy_empty, mst_full,
        output phy_rd_en, mst_din, mst_wr_en
    );

    modport slave (
        output phy_dout, phy_empty, mst_full,
        input  phy_rd_en, mst_din, mst_wr_en
    );
endinterface

// File: rtl/rx_dma_writer.sv
// Drains PHY RX frames into a host ring as memory-write bursts plus a per-frame header.
// Define RX_TIMESTAMP_EN to store the latched global_counter[31:0] in header DW1.
`timescale 1ns/1ps
module rx_dma_writer #(
    parameter int unsigned MAX_PAYLOAD_DW = 32,
    parameter int unsigned MAX_FRAME_DW   = 386
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    rx_dma_writer_if.master bus,
    input  logic [63:0]     global_counter,
    input  logic [7:0]      dma_status,
    input  logic [19:0]     dma_length,
    input  logic [29:0]     dma_addr_start,
    output logic [29:0]     dma_addr_cur,
    output logic            sys_intr,
    output logic [15:0]     drop_count
);
    localparam int unsigned AW = (MAX_PAYLOAD_DW > 1) ? $clog2(MAX_PAYLOAD_DW) : 1;
    localparam int unsigned CW = $clog2(MAX_PAYLOAD_DW + 1);
    localparam int unsigned IW = $clog2(2 * MAX_PAYLOAD_DW + 4);
    localparam logic [CW-1:0] FULL_M1  = CW'(MAX_PAYLOAD_DW - 1);
    localparam logic [CW-1:0] FULL     = CW'(MAX_PAYLOAD_DW);
    localparam logic [29:0]   FRAME_DW = 30'(MAX_FRAME_DW);

    typedef enum logic [2:0] {IDLE, WRAP_CHK, FILL, EMIT, HDR, DONE, DROP} state_t;
    state_t state, state_nx;

    logic          rd_pend;
    logic          hold_vld;
    logic [17:0]   hold_word;
    logic [31:0]   dbuf [0:(1<<AW)-1];
    logic [CW-1:0] dw_cnt;
    logic          half_sel;
    logic          eof;
    logic [15:0]   byte_cnt;
    logic [29:0]   slot;
    logic [29:0]   data_addr;
    logic [29:0]   cur;
    logic [IW-1:0] idx;

    logic          word_vld;
    logic [17:0]   word;
    logic          room;
    logic [CW-1:0] blen;
    logic [29:0]   baddr;
    logic [31:0]   hdr0;
    logic [31:0]   hdr1;
    logic [31:0]   bdw;
    logic [IW-1:0] pidx;
    logic [IW-1:0] idx_last;
    logic [29:0]   wrap_base;
    logic [16:0]   bc_round;
    logic          unused_bits;

    // The frame-start word seen in IDLE is parked in hold_word and replayed as FILL's first word.
    assign word_vld  = hold_vld | rd_pend;
    assign word      = hold_vld ? hold_word : bus.phy_dout;
    assign room      = dw_cnt < FULL;
    assign blen      = (state == HDR) ? CW'(2) : dw_cnt + CW'(half_sel);
    assign baddr     = (state == HDR) ? slot : data_addr;
    assign pidx      = idx - IW'(3);
    assign idx_last  = IW'({blen, 1'b0}) + IW'(2);
    assign hdr0      = {byte_cnt, 16'h5555};
    assign bdw       = (state == HDR) ? (pidx[1] ? hdr1 : hdr0) : dbuf[pidx[AW:1]];
    assign wrap_base = (cur + FRAME_DW > dma_addr_start + 30'(dma_length)) ? dma_addr_start : cur;
    assign bc_round  = {1'b0, byte_cnt} + 17'd3;

    assign dma_addr_cur = cur;

`ifdef RX_TIMESTAMP_EN
    logic [31:0] ts;
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            ts <= '0;
        else if (state == WRAP_CHK)
            ts <= global_counter[31:0];
    end
    assign hdr1        = ts;
    assign unused_bits = ^{dma_status[7:1], global_counter[63:32], pidx, bc_round[1:0]};
`else
    assign hdr1        = '0;
    assign unused_bits = ^{dma_status[7:1], global_counter, pidx, bc_round[1:0]};
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.phy_rd_en = 1'b0;
        bus.mst_wr_en = 1'b0;
        bus.mst_din   = '0;
        sys_intr      = 1'b0;
        case (state)
            IDLE: begin
                bus.phy_rd_en = !bus.phy_empty && !rd_pend;
                if (rd_pend && word[17])
                    state_nx = dma_status[0] ? WRAP_CHK : DROP;
            end
            WRAP_CHK: state_nx = FILL;
            FILL: begin
                bus.phy_rd_en = !bus.phy_empty && !word_vld && room;
                if (word_vld) begin
                    if (!word[17])
                        state_nx = (dw_cnt == '0 && !half_sel) ? HDR : EMIT;
                    else if (half_sel && dw_cnt == FULL_M1)
                        state_nx = EMIT;
                end
            end
            EMIT, HDR: begin
                bus.mst_wr_en = !bus.mst_full;
                if (idx == '0)
                    bus.mst_din = {2'b10, 6'h0, 10'(blen)};
                else if (idx == IW'(1))
                    bus.mst_din = {2'b00, baddr[29:14]};
                else if (idx == IW'(2))
                    bus.mst_din = {2'b00, baddr[13:0], 2'b00};
                else
                    bus.mst_din = {(idx == idx_last) ? 2'b01 : 2'b00,
                                   pidx[0] ? bdw[15:0] : bdw[31:16]};
                if (!bus.mst_full && idx == idx_last)
                    state_nx = (state == HDR) ? DONE : (eof ? HDR : FILL);
            end
            DONE: begin
                sys_intr = 1'b1;
                state_nx = IDLE;
            end
            DROP: begin
                bus.phy_rd_en = !bus.phy_empty && !rd_pend;
                if (rd_pend && !word[17])
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (sys_rst) begin
            bus.phy_rd_en = 1'b0;
            bus.mst_wr_en = 1'b0;
            sys_intr      = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_pend    <= 1'b0;
            hold_vld   <= 1'b0;
            hold_word  <= '0;
            dw_cnt     <= '0;
            half_sel   <= 1'b0;
            eof        <= 1'b0;
            byte_cnt   <= '0;
            slot       <= '0;
            data_addr  <= '0;
            cur        <= dma_addr_start;
            idx        <= '0;
            drop_count <= '0;
        end else begin
            rd_pend <= bus.phy_rd_en;
            case (state)
                IDLE: begin
                    if (rd_pend && word[17] && dma_status[0]) begin
                        hold_vld  <= 1'b1;
                        hold_word <= word;
                    end
                end
                WRAP_CHK: begin
                    slot      <= wrap_base;
                    data_addr <= wrap_base + 30'd2;
                    cur       <= wrap_base;
                    byte_cnt  <= '0;
                    eof       <= 1'b0;
                end
                FILL: begin
                    if (word_vld) begin
                        hold_vld <= 1'b0;
                        if (word[17]) begin
                            half_sel <= !half_sel;
                            if (half_sel)
                                dw_cnt <= dw_cnt + CW'(1);
                            byte_cnt <= byte_cnt + (word[16] ? 16'd2 : 16'd1);
                        end else begin
                            eof <= 1'b1;
                        end
                    end
                end
                EMIT, HDR: begin
                    if (!bus.mst_full) begin
                        if (idx == idx_last) begin
                            idx <= '0;
                            if (state == EMIT) begin
                                data_addr <= data_addr + 30'(blen);
                                dw_cnt    <= '0;
                                half_sel  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                DONE: cur <= slot + 30'd2 + 30'(bc_round[16:2]);
                DROP: begin
                    if (rd_pend && !word[17] && drop_count != '1)
                        drop_count <= drop_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // First halfword of a DW also zeroes the low half so an odd count ends padded.
    always_ff @(posedge sys_clk) begin
        if (state == FILL && word_vld && word[17]) begin
            if (!half_sel)
                dbuf[dw_cnt[AW-1:0]] <= {word[15:0], 16'h0000};
            else
                dbuf[dw_cnt[AW-1:0]][15:0] <= word[15:0];
        end
    end
endmodule

// File: tb/tb_rx_dma_writer.sv
// Directed scoreboard bench for rx_dma_writer: PHY FIFO model, command-word capture, ring model.
`timescale 1ns/1ps
module tb_rx_dma_writer;
    localparam int unsigned MAXP = 32;
    localparam int unsigned MAXF = 386;
    localparam logic [29:0] S    = 30'h0400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] gc;
    logic [7:0]  status;
    logic [19:0] len;
    logic [29:0] start;
    logic [29:0] cur;
    logic        intr;
    logic [15:0] drops;

    always #4 clk = ~clk;

    rx_dma_writer_if bus();

    rx_dma_writer #(.MAX_PAYLOAD_DW(MAXP), .MAX_FRAME_DW(MAXF)) dut (
        .sys_clk        (clk),
        .sys_rst        (rst),
        .bus            (bus),
        .global_counter (gc),
        .dma_status     (status),
        .dma_length     (len),
        .dma_addr_start (start),
        .dma_addr_cur   (cur),
        .sys_intr       (intr),
        .drop_count     (drops)
    );

    logic [17:0] phy_q[$];
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int unsigned intr_cnt;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [29:0] mcur;

    always @(posedge clk) begin
        if (rst)
            phy_q.delete();
        else if (bus.phy_rd_en && phy_q.size() > 0)
            bus.phy_dout <= phy_q.pop_front();
        bus.phy_empty <= (phy_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst)
            intr_cnt = 0;
        else begin
            if (bus.mst_wr_en)
                got_q.push_back(bus.mst_din);
            if (intr)
                intr_cnt = intr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int unsigned nbytes, input logic [7:0] seed);
        for (int unsigned h = 0; h < (nbytes + 1) / 2; h++) begin
            logic       odd_end;
            logic [7:0] b0, b1;
            odd_end = (2 * h + 1 >= nbytes);
            b0 = seed + 8'(2 * h);
            b1 = odd_end ? 8'h00 : seed + 8'(2 * h + 1);
            phy_q.push_back({1'b1, !odd_end, b0, b1});
        end
        phy_q.push_back(18'h0_0000);
    endtask

    task automatic push_cmd(input logic [29:0] a, input int unsigned n);
        exp_q.push_back({2'b10, 6'h0, 10'(n)});
        exp_q.push_back({2'b00, a[29:14]});
        exp_q.push_back({2'b00, a[13:0], 2'b00});
    endtask

    task automatic expect_frame(input int unsigned nbytes, input logic [7:0] seed);
        logic [29:0] fslot, da;
        logic [15:0] hw[$];
        logic [31:0] dw[$];
        logic [31:0] tsv;
        int unsigned nh;
        nh = (nbytes + 1) / 2;
`ifdef RX_TIMESTAMP_EN
        tsv = gc[31:0];
`else
        tsv = 32'h0;
`endif
        fslot = (mcur + 30'(MAXF) > start + 30'(len)) ? start : mcur;
        for (int unsigned h = 0; h < nh; h++) begin
            logic [7:0] b0, b1;
            b0 = seed + 8'(2 * h);
            b1 = (2 * h + 1 < nbytes) ? seed + 8'(2 * h + 1) : 8'h00;
            hw.push_back({b0, b1});
        end
        if (nh % 2 == 1)
            hw.push_back(16'h0000);
        for (int unsigned k = 0; k < hw.size() / 2; k++)
            dw.push_back({hw[2 * k], hw[2 * k + 1]});
        da = fslot + 30'd2;
        for (int unsigned base = 0; base < dw.size(); base += MAXP) begin
            int unsigned n;
            n = (dw.size() - base > MAXP) ? MAXP : dw.size() - base;
            push_cmd(da, n);
            for (int unsigned i = 0; i < n; i++) begin
                logic [31:0] d;
                d = dw[base + i];
                exp_q.push_back({2'b00, d[31:16]});
                exp_q.push_back({(i == n - 1) ? 2'b01 : 2'b00, d[15:0]});
            end
            da = da + 30'(n);
        end
        push_cmd(fslot, 2);
        exp_q.push_back({2'b00, 16'(nbytes)});
        exp_q.push_back({2'b00, 16'h5555});
        exp_q.push_back({2'b00, tsv[31:16]});
        exp_q.push_back({2'b01, tsv[15:0]});
        mcur = fslot + 30'd2 + 30'((nbytes + 3) / 4);
    endtask

    task automatic wait_frame(input string tag, input int unsigned target);
        int unsigned c;
        c = 0;
        while (intr_cnt < target && c < 5000) begin
            step(1);
            c++;
        end
        step(2);
        check({tag, "_intr"}, 64'(intr_cnt), 64'(target));
        check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_word"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
        check({tag, "_cur"}, 64'(cur), 64'(mcur));
    endtask

    initial begin
        int unsigned tgt;
        int unsigned c;
        int unsigned busy;
        tgt          = 0;
        rst          = 1'b1;
        status       = 8'h01;
        len          = 20'hF_FFFF;
        start        = S;
        gc           = 64'h0;
        bus.mst_full = 1'b0;
        mcur         = S;
        step(3);
        check("rst_phy_rd_en", 64'(bus.phy_rd_en), 64'd0);
        check("rst_mst_wr_en", 64'(bus.mst_wr_en), 64'd0);
        check("rst_mst_din",   64'(bus.mst_din),   64'd0);
        check("rst_intr",      64'(intr),          64'd0);
        check("rst_drops",     64'(drops),         64'd0);
        check("rst_cur",       64'(cur),           64'(S));
        rst = 1'b0;
        step(2);

        // 64-byte frame at the ring base
        gc = 64'hFEED_0000_C0DE_0001;
        send_frame(64, 8'h10);
        expect_frame(64, 8'h10);
        wait_frame("f64", ++tgt);
        check("f64_cur_const", 64'(cur), 64'(30'h0400_0012));

        // idle filler word, then 61-byte frame with a trailing single byte
        gc = 64'hFEED_0000_C0DE_0002;
        phy_q.push_back(18'h0_1234);
        send_frame(61, 8'h20);
        expect_frame(61, 8'h20);
        wait_frame("f61", ++tgt);
        check("f61_cur_const", 64'(cur), 64'(S + 30'd36));

        // 200-byte frame split into 32 + 18 DW bursts
        gc = 64'hFEED_0000_C0DE_0003;
        send_frame(200, 8'h30);
        expect_frame(200, 8'h30);
        wait_frame("f200", ++tgt);
        check("f200_cur_const", 64'(cur), 64'(S + 30'd88));

        // ring end 100 DW past cur: the next slot wraps to the base
        len = 20'd188;
        gc  = 64'hFEED_0000_C0DE_0004;
        send_frame(64, 8'h40);
        expect_frame(64, 8'h40);
        wait_frame("wrap", ++tgt);
        check("wrap_cur_const", 64'(cur), 64'(S + 30'd18));

        // master FIFO full for 20 cycles in the middle of the first burst
        gc = 64'hFEED_0000_C0DE_0005;
        send_frame(200, 8'h50);
        expect_frame(200, 8'h50);
        c = 0;
        while (got_q.size() < 10 && c < 3000) begin
            step(1);
            c++;
        end
        check("stall_started", 64'(got_q.size() >= 10), 64'd1);
        bus.mst_full = 1'b1;
        busy = 0;
        repeat (20) begin
            step(1);
            if (bus.mst_wr_en || bus.phy_rd_en)
                busy++;
        end
        check("stall_quiet", 64'(busy), 64'd0);
        check("stall_phy_backlog", 64'(bus.phy_empty), 64'd0);
        bus.mst_full = 1'b0;
        wait_frame("stall", ++tgt);

        // disable while a frame is in progress: it still completes
        gc = 64'hFEED_0000_C0DE_0006;
        send_frame(40, 8'h60);
        expect_frame(40, 8'h60);
        step(8);
        status = 8'h00;
        wait_frame("dis_mid", ++tgt);

        // three frames while disabled are dropped
        send_frame(10, 8'h70);
        send_frame(12, 8'h80);
        send_frame(6, 8'h90);
        c = 0;
        while (drops != 16'd3 && c < 3000) begin
            step(1);
            c++;
        end
        step(10);
        check("drop_count", 64'(drops), 64'd3);
        check("drop_no_writes", 64'(got_q.size()), 64'd0);
        check("drop_no_intr", 64'(intr_cnt), 64'(tgt));
        check("drop_cur", 64'(cur), 64'(mcur));

        // reset in the middle of a burst abandons the frame
        status = 8'h01;
        send_frame(200, 8'hA0);
        c = 0;
        while (got_q.size() < 20 && c < 3000) begin
            step(1);
            c++;
        end
        rst = 1'b1;
        step(2);
        check("mid_rst_cur", 64'(cur), 64'(S));
        check("mid_rst_drops", 64'(drops), 64'd0);
        check("mid_rst_wr_en", 64'(bus.mst_wr_en), 64'd0);
        got_q.delete();
        mcur = S;
        rst  = 1'b0;
        step(50);
        check("mid_rst_no_hdr", 64'(got_q.size()), 64'd0);
        check("mid_rst_no_intr", 64'(intr_cnt), 64'd0);

        // normal operation resumes from the ring base
        tgt = 0;
        gc  = 64'hFEED_0000_C0DE_0007;
        send_frame(30, 8'hB0);
        expect_frame(30, 8'hB0);
        wait_frame("post_rst", ++tgt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
